// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared types for the traffic phase controller.
//   phase_t      : phase codes (STOP/HOLD/GO/SLOW). These are the same codes
//                  used by the start_sel input and the phase output.
//   LIGHT_*      : 2-bit per-approach light codes. Code 2'b11 is never driven.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_STOP = 2'd0,
    PH_HOLD = 2'd1,
    PH_GO   = 2'd2,
    PH_SLOW = 2'd3
  } phase_t;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Free-running divider that counts 0..TICK_DIV-1 while enable is high.
// It asserts tick during the cycle in which the count sits at TICK_DIV-1.
// When enable is low the count holds, so a pending tick is not lost.
// Ports:
//   clk    in  : system clock
//   reset  in  : synchronous active-high reset, clears the count
//   enable in  : advance the count this cycle
//   tick   out : one-cycle pulse on the last count of each period
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_reg;

  assign tick = enable && (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (enable) begin
      if (count_reg == LAST) count_reg <= '0;
      else                   count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
// Sequences N_DIR approaches through STOP -> GO(0) -> SLOW(0) -> HOLD ->
// GO(1) -> ... The countdown advances once per prescaler tick. Each rising
// edge of pause toggles a freeze. A latched pedestrian request for an approach
// lengthens that approach's next green and lights its walk indication.
// Ports:
//   clk        in  : system clock
//   reset      in  : synchronous active-high reset (samples start_sel)
//   pause      in  : level input; each rising edge toggles paused
//   start_sel  in  : phase entered at reset (phase_t encoding)
//   ped_req    in  : per-approach pedestrian request (pulse or level)
//   light      out : 2 bits per approach, approach d at [2d+1:2d]
//   active_dir out : approach owning the current GO/SLOW phase
//   phase      out : current phase code
//   remaining  out : ticks left in the phase, minus one
//   ped_walk   out : walk indication, high for a whole extended GO
//   paused     out : high while frozen
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR      = 2,
  parameter int TICK_DIV   = 50_000_000,
  parameter int CNT_W      = 8,
  parameter int STOP_TICKS = 3,
  parameter int GO_TICKS   = 8,
  parameter int SLOW_TICKS = 3,
  parameter int HOLD_TICKS = 2,
  parameter int PED_EXTRA  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pause,
  input  logic [1:0]                 start_sel,
  input  logic [N_DIR-1:0]           ped_req,
  output logic [2*N_DIR-1:0]         light,
  output logic [$clog2(N_DIR)-1:0]   active_dir,
  output logic [1:0]                 phase,
  output logic [CNT_W-1:0]           remaining,
  output logic [N_DIR-1:0]           ped_walk,
  output logic                       paused
);

  localparam int DIR_W = $clog2(N_DIR);

  function automatic logic [CNT_W-1:0] phase_load(input phase_t p);
    case (p)
      PH_STOP: phase_load = CNT_W'(STOP_TICKS - 1);
      PH_HOLD: phase_load = CNT_W'(HOLD_TICKS - 1);
      PH_GO:   phase_load = CNT_W'(GO_TICKS - 1);
      default: phase_load = CNT_W'(SLOW_TICKS - 1);
    endcase
  endfunction

  phase_t             phase_reg, phase_next;
  logic [DIR_W-1:0]   dir_reg, dir_next;
  logic [CNT_W-1:0]   rem_reg, rem_next;
  logic [N_DIR-1:0]   walk_reg, walk_next;
  logic [N_DIR-1:0]   latch_reg, latch_next;
  // Requests that arrive while an approach is already green. They must
  // survive the latch clear at that approach's SLOW entry.
  logic [N_DIR-1:0]   late_reg, late_next;
  logic               paused_reg;
  logic               pause_d_reg;

  logic               pause_rise;
  logic               run;
  logic               tick;
  logic               enter_go;
  logic               enter_slow;
  logic [N_DIR-1:0]   req_now;

  assign pause_rise = pause && !pause_d_reg;
  // A rising pause edge freezes this very cycle. This gives pause priority over
  // a coincident final tick, and the prescaler keeps its value.
  assign run        = !paused_reg && !pause_rise;
  assign req_now    = latch_reg | ped_req;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (run),
    .tick   (tick)
  );

  always_comb begin
    phase_next = phase_reg;
    dir_next   = dir_reg;
    rem_next   = rem_reg;
    walk_next  = walk_reg;
    enter_go   = 1'b0;
    enter_slow = 1'b0;
    if (tick) begin
      if (rem_reg != '0) begin
        rem_next = rem_reg - CNT_W'(1);
      end else begin
        case (phase_reg)
          PH_STOP: begin
            phase_next = PH_GO;
            dir_next   = '0;
            enter_go   = 1'b1;
          end
          PH_HOLD: begin
            phase_next = PH_GO;
            dir_next   = (dir_reg == DIR_W'(N_DIR - 1)) ? '0 : dir_reg + DIR_W'(1);
            enter_go   = 1'b1;
          end
          PH_GO: begin
            phase_next = PH_SLOW;
            rem_next   = phase_load(PH_SLOW);
            walk_next  = '0;
            enter_slow = 1'b1;
          end
          default: begin
            phase_next = PH_HOLD;
            rem_next   = phase_load(PH_HOLD);
          end
        endcase
      end
    end
    // A request present on the entry cycle itself counts as latched.
    if (enter_go) begin
      walk_next = '0;
      if (req_now[dir_next]) begin
        rem_next            = CNT_W'(GO_TICKS + PED_EXTRA - 1);
        walk_next[dir_next] = 1'b1;
      end else begin
        rem_next = phase_load(PH_GO);
      end
    end
  end

  for (genvar gi = 0; gi < N_DIR; gi++) begin : g_dir
    logic owner;
    assign owner = (dir_reg == DIR_W'(gi));
    // At SLOW entry the serviced request is dropped. Requests seen during the
    // green, or on the entry cycle itself, are kept for the next GO.
    assign latch_next[gi] = (enter_slow && owner) ? (late_reg[gi] | ped_req[gi])
                                                  : (latch_reg[gi] | ped_req[gi]);
    assign late_next[gi]  = (enter_slow && owner) ? 1'b0
                          : (phase_reg == PH_GO && owner) ? (late_reg[gi] | ped_req[gi])
                          : late_reg[gi];
    assign light[2*gi +: 2] = !owner                  ? LIGHT_RED
                            : (phase_reg == PH_GO)    ? LIGHT_GREEN
                            : (phase_reg == PH_SLOW)  ? LIGHT_YELLOW
                            :                           LIGHT_RED;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg   <= phase_t'(start_sel);
      dir_reg     <= '0;
      rem_reg     <= phase_load(phase_t'(start_sel));
      walk_reg    <= '0;
      latch_reg   <= '0;
      late_reg    <= '0;
      paused_reg  <= 1'b0;
      pause_d_reg <= 1'b0;
    end else begin
      phase_reg   <= phase_next;
      dir_reg     <= dir_next;
      rem_reg     <= rem_next;
      walk_reg    <= walk_next;
      latch_reg   <= latch_next;
      late_reg    <= late_next;
      pause_d_reg <= pause;
      if (pause_rise) paused_reg <= !paused_reg;
    end
  end

  assign active_dir = dir_reg;
  assign phase      = phase_reg;
  assign remaining  = rem_reg;
  assign ped_walk   = walk_reg;
  assign paused     = paused_reg;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl
// Self-checking bench for traffic_phase_ctrl. It uses N_DIR=2, TICK_DIV=2,
// STOP=3, GO=4, SLOW=2, HOLD=1 and PED_EXTRA=2. A reference model follows the
// phase rules in terms of elapsed running cycles per phase and a per-approach
// pending-request set. Each scenario task compares the DUT against the model
// and against fixed expected values.
module tb_traffic_phase_ctrl;

  localparam int ND = 2;
  localparam int TD = 2;
  localparam int CW = 8;
  localparam int D_STOP = 3;
  localparam int D_GO   = 4;
  localparam int D_SLOW = 2;
  localparam int D_HOLD = 1;
  localparam int D_PED  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pause = 1'b0;
  logic [1:0]    start_sel = 2'b00;
  logic [1:0]    ped_req = 2'b00;
  logic [3:0]    light;
  logic [0:0]    active_dir;
  logic [1:0]    phase;
  logic [CW-1:0] remaining;
  logic [1:0]    ped_walk;
  logic          paused;

  int n_cmp  = 0;
  int n_fail = 0;

  traffic_phase_ctrl #(
    .N_DIR(ND), .TICK_DIV(TD), .CNT_W(CW), .STOP_TICKS(D_STOP), .GO_TICKS(D_GO),
    .SLOW_TICKS(D_SLOW), .HOLD_TICKS(D_HOLD), .PED_EXTRA(D_PED)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause), .start_sel(start_sel), .ped_req(ped_req),
    .light(light), .active_dir(active_dir), .phase(phase), .remaining(remaining),
    .ped_walk(ped_walk), .paused(paused)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_phase;   // 0 STOP, 1 HOLD, 2 GO, 3 SLOW
  int         m_dir;
  int         m_len;     // phase length in ticks
  int         m_e;       // running cycles spent in the current phase
  logic       m_paused;
  logic       m_prev;
  logic [1:0] m_pend;    // requests waiting for their approach's next green
  logic [1:0] m_walk;

  function automatic int dur_of(input int p);
    case (p)
      0: return D_STOP;
      1: return D_HOLD;
      2: return D_GO;
      default: return D_SLOW;
    endcase
  endfunction

  task automatic model_clock();
    logic rise;
    logic served;
    if (reset) begin
      m_phase = int'(start_sel); m_dir = 0; m_len = dur_of(m_phase); m_e = 0;
      m_paused = 1'b0; m_prev = 1'b0; m_pend = 2'b00; m_walk = 2'b00;
    end else begin
      rise   = pause && !m_prev;
      m_prev = pause;
      m_pend = m_pend | ped_req;
      if (!m_paused && !rise) begin
        m_e++;
        if (m_e == m_len * TD) begin
          m_e = 0;
          case (m_phase)
            2: begin m_phase = 3; m_len = D_SLOW; m_walk = 2'b00; end
            3: begin m_phase = 1; m_len = D_HOLD; end
            default: begin
              m_dir   = (m_phase == 0) ? 0 : (m_dir + 1) % ND;
              m_phase = 2;
              served  = m_pend[m_dir];
              m_walk  = 2'b00;
              if (served) begin
                m_pend[m_dir] = 1'b0;
                m_walk[m_dir] = 1'b1;
                m_len = D_GO + D_PED;
              end else begin
                m_len = D_GO;
              end
            end
          endcase
        end
      end
      if (rise) m_paused = !m_paused;
    end
  endtask

  function automatic logic [17:0] exp_vec();
    logic [3:0] l;
    l = 4'b0000;
    if (m_phase == 2)      l[2*m_dir +: 2] = 2'b10;
    else if (m_phase == 3) l[2*m_dir +: 2] = 2'b01;
    return {l, 1'(m_dir), 2'(m_phase), 8'(m_len - 1 - m_e / TD), m_walk, m_paused};
  endfunction

  task automatic step(input logic rst, input logic p, input logic [1:0] ss, input logic [1:0] req);
    reset = rst; pause = p; start_sel = ss; ped_req = req;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [17:0] obs;
    step(1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b1, 1'b0, 2'b00, 2'b00);
    n_cmp++;
    if (phase !== 2'd0 || light !== 4'b0000 || remaining !== 8'd2 || paused !== 1'b0 ||
        ped_walk !== 2'b00 || active_dir !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: phase=%0d light=%b rem=%0d paused=%b walk=%b dir=%0d, required 0 0000 2 0 00 0",
               phase, light, remaining, paused, ped_walk, active_dir);
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, 2'b00, 2'b00);
      obs = {light, active_dir, phase, remaining, ped_walk, paused};
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_run cyc %0d: got %h, required %h", i, obs, exp_vec());
      end
      if (i >= 5 && i <= 12) begin
        n_cmp++;
        if (phase !== 2'd2 || light !== 4'b0010 || remaining !== 8'(3 - (i - 5) / 2)) begin
          n_fail++;
          $display("FAIL go0_countdown cyc %0d: phase=%0d light=%b rem=%0d, required 2 0010 %0d",
                   i, phase, light, remaining, 3 - (i - 5) / 2);
        end
      end
      if (i == 13 || i == 17 || i == 19) begin
        n_cmp++;
        if ((i == 13 && (phase !== 2'd3 || light !== 4'b0001)) ||
            (i == 17 && (phase !== 2'd1 || light !== 4'b0000)) ||
            (i == 19 && (phase !== 2'd2 || light !== 4'b1000 || active_dir !== 1'b1))) begin
          n_fail++;
          $display("FAIL reset_seq cyc %0d: phase=%0d light=%b dir=%0d", i, phase, light, active_dir);
        end
      end
    end
    $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_fail);
  endtask

  task automatic test_start_sel();
    logic [17:0] obs;
    for (int s = 1; s < 4; s++) begin
      step(1'b1, 1'b0, 2'(s), 2'b00);
      n_cmp++;
      if ((s == 1 && (phase !== 2'd1 || remaining !== 8'd0 || light !== 4'b0000)) ||
          (s == 2 && (phase !== 2'd2 || remaining !== 8'd3 || light !== 4'b0010 || ped_walk !== 2'b00)) ||
          (s == 3 && (phase !== 2'd3 || remaining !== 8'd1 || light[1:0] !== 2'b01))) begin
        n_fail++;
        $display("FAIL start_sel_%0d: phase=%0d rem=%0d light=%b walk=%b", s, phase, remaining, light, ped_walk);
      end
      for (int i = 0; i < 6; i++) begin
        step(1'b0, 1'b0, 2'(s), 2'b00);
        obs = {light, active_dir, phase, remaining, ped_walk, paused};
        n_cmp++;
        if (obs !== exp_vec()) begin
          n_fail++;
          $display("FAIL start_run_%0d cyc %0d: got %h, required %h", s, i, obs, exp_vec());
        end
        if (s == 1 && i == 1) begin
          n_cmp++;
          if (phase !== 2'd2 || active_dir !== 1'b1 || light !== 4'b1000) begin
            n_fail++;
            $display("FAIL hold_to_go1: phase=%0d dir=%0d light=%b, required 2 1 1000", phase, active_dir, light);
          end
        end
      end
      $display("test_start_sel start_sel=%0d done", s);
    end
  endtask

  task automatic test_pause();
    logic [17:0] obs;
    step(1'b1, 1'b0, 2'b10, 2'b00);
    for (int i = 0; i < 52; i++) begin
      step(1'b0, (i == 2 || i == 3 || i == 44), 2'b10, 2'b00);
      obs = {light, active_dir, phase, remaining, ped_walk, paused};
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL pause_run cyc %0d: got %h, required %h", i, obs, exp_vec());
      end
      if (i >= 4 && i <= 43) begin
        n_cmp++;
        if (paused !== 1'b1 || phase !== 2'd2 || remaining !== 8'd2 || light !== 4'b0010) begin
          n_fail++;
          $display("FAIL pause_frozen cyc %0d: paused=%b phase=%0d rem=%0d light=%b", i, paused, phase, remaining, light);
        end
      end
      if (i == 49 || i == 50) begin
        n_cmp++;
        if (paused !== 1'b0 || phase !== ((i == 49) ? 2'd2 : 2'd3)) begin
          n_fail++;
          $display("FAIL pause_resume cyc %0d: paused=%b phase=%0d", i, paused, phase);
        end
      end
    end
    $display("test_pause done: compared=%0d mismatched=%0d", n_cmp, n_fail);
  endtask

  task automatic test_ped();
    logic [17:0] obs;
    int go1_run;
    int go1_len[2];
    int walk_cnt;
    logic was_go1;
    go1_run = 0; go1_len[0] = 0; go1_len[1] = 0; walk_cnt = 0; was_go1 = 1'b0;
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b0, 2'b00, (i == 7) ? 2'b10 : 2'b00);
      obs = {light, active_dir, phase, remaining, ped_walk, paused};
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL ped_run cyc %0d: got %h, required %h", i, obs, exp_vec());
      end
      if (phase == 2'd2 && active_dir == 1'b1) begin
        if (!was_go1) go1_run++;
        if (go1_run <= 2) go1_len[go1_run-1]++;
        was_go1 = 1'b1;
      end else begin
        was_go1 = 1'b0;
      end
      if (ped_walk == 2'b10) walk_cnt++;
      if (i == 19) begin
        n_cmp++;
        if (remaining !== 8'd5 || ped_walk !== 2'b10) begin
          n_fail++;
          $display("FAIL ped_go1_entry: rem=%0d walk=%b, required 5 10", remaining, ped_walk);
        end
      end
    end
    n_cmp++;
    if (go1_len[0] != 12 || go1_len[1] != 8 || walk_cnt != 12) begin
      n_fail++;
      $display("FAIL ped_durations: go1 first=%0d second=%0d walk=%0d, required 12 8 12",
               go1_len[0], go1_len[1], walk_cnt);
    end
    $display("test_ped done: go1 lengths %0d/%0d walk %0d", go1_len[0], go1_len[1], walk_cnt);
  endtask

  task automatic test_coincident();
    logic [17:0] obs;
    step(1'b1, 1'b0, 2'b11, 2'b00);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, (i == 3 || i == 10), 2'b11, 2'b00);
      obs = {light, active_dir, phase, remaining, ped_walk, paused};
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL coin_pause cyc %0d: got %h, required %h", i, obs, exp_vec());
      end
      if (i >= 3 && i <= 11) begin
        n_cmp++;
        if (phase !== ((i == 11) ? 2'd1 : 2'd3) || paused !== ((i >= 3 && i <= 9) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL coin_pause_phase cyc %0d: phase=%0d paused=%b", i, phase, paused);
        end
      end
    end
    step(1'b1, 1'b0, 2'b10, 2'b00);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 2'b10, (i == 7) ? 2'b01 : 2'b00);
      obs = {light, active_dir, phase, remaining, ped_walk, paused};
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL coin_ped cyc %0d: got %h, required %h", i, obs, exp_vec());
      end
      if (i == 27) begin
        n_cmp++;
        if (phase !== 2'd2 || active_dir !== 1'b0 || remaining !== 8'd5 || ped_walk !== 2'b01) begin
          n_fail++;
          $display("FAIL coin_ped_go0: phase=%0d dir=%0d rem=%0d walk=%b, required 2 0 5 01",
                   phase, active_dir, remaining, ped_walk);
        end
      end
    end
    $display("test_coincident done: compared=%0d mismatched=%0d", n_cmp, n_fail);
  endtask

  task automatic test_reset_mid();
    logic [17:0] obs;
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 28; i++) begin
      step(1'b0, (i == 22), 2'b00, (i == 7) ? 2'b10 : 2'b00);
      obs = {light, active_dir, phase, remaining, ped_walk, paused};
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_run cyc %0d: got %h, required %h", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (paused !== 1'b1 || ped_walk !== 2'b10 || phase !== 2'd2 || active_dir !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_before: paused=%b walk=%b phase=%0d dir=%0d, required 1 10 2 1",
               paused, ped_walk, phase, active_dir);
    end
    step(1'b1, 1'b0, 2'b10, 2'b00);
    n_cmp++;
    if (paused !== 1'b0 || phase !== 2'd2 || active_dir !== 1'b0 || remaining !== 8'd3 || ped_walk !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset: paused=%b phase=%0d dir=%0d rem=%0d walk=%b, required 0 2 0 3 00",
               paused, phase, active_dir, remaining, ped_walk);
    end
    $display("test_reset_mid done: compared=%0d mismatched=%0d", n_cmp, n_fail);
  endtask

  task automatic test_random();
    logic [17:0] obs;
    logic p;
    logic r;
    logic [1:0] ss;
    logic [1:0] req;
    int errs;
    p = 1'b0; ss = 2'b00; errs = n_fail;
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 23) == 0) p = !p;
      r   = ($urandom_range(0, 299) == 0);
      if (r) ss = 2'($urandom_range(0, 3));
      req = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(r, p, ss, req);
      obs = {light, active_dir, phase, remaining, ped_walk, paused};
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h, required %h", i, obs, exp_vec());
      end
    end
    $display("test_random done: 3000 cycles, new mismatches %0d", n_fail - errs);
  endtask

  initial begin
    test_reset();
    test_start_sel();
    test_pause();
    test_ped();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised multi-approach traffic-light phase controller, the next generation of the board-level `Main_traffic` controller. It sequences N approaches through GO/SLOW/HOLD phases with configurable per-phase durations, a start phase selected at reset, pause/resume toggling and latched pedestrian requests that extend green. Outputs are encoded light states plus a countdown for display. A top-level wrapper maps them to LEDR/HEX.

## Interface
- `N_DIR`, 2: number of approaches, range 2..4.
- `TICK_DIV`, 50_000_000: clock cycles per phase tick, must be ≥1.
- `CNT_W`, 8: countdown counter width.
- `STOP_TICKS`, 3: duration of the initial all-red phase.
- `GO_TICKS`, 8: duration of green.
- `SLOW_TICKS`, 3: duration of yellow.
- `HOLD_TICKS`, 2: duration of the all-red clearance phase.
- `PED_EXTRA`, 4: green extension when a pedestrian request is serviced.
- Every duration must be ≥1 and fit in `CNT_W`, including `GO_TICKS+PED_EXTRA`.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `pause` in 1: level input. Each rising edge toggles the paused state.
- `start_sel` in 2: start phase, sampled only while `reset`=1. Encoding: 00 STOP, 01 HOLD, 10 GO, 11 SLOW.
- `ped_req` in N_DIR: per-approach pedestrian request, pulse or level.
- `light` out 2*N_DIR: per-approach light code, with approach d at bits [2d+1:2d]. Codes: 00 red, 01 yellow, 10 green.
- `active_dir` out clog2(N_DIR): approach that owns the current GO/SLOW phase.
- `phase` out 2: current phase code, same encoding as `start_sel`.
- `remaining` out CNT_W: ticks left in the phase, minus 1.
- `ped_walk` out N_DIR: walk indication.
- `paused` out 1: 1 while frozen.

## Operation
- **Phases and transitions** (on the last tick of a phase):
  - STOP → GO(dir 0)
  - GO(d) → SLOW(d)
  - SLOW(d) → HOLD
  - HOLD → GO((d+1) mod N_DIR)
- **Lights:**
  - GO(d): approach d green, all others red.
  - SLOW(d): approach d yellow, all others red.
  - STOP and HOLD: all red.
  - Light code 11 is never driven.
- **Tick:** a prescaler counts 0..TICK_DIV-1 and asserts the tick when it reaches TICK_DIV-1.
- **Countdown:**
  - On phase entry, `remaining` loads duration-1.
  - Each tick decrements `remaining`.
  - A tick with `remaining`=0 performs the phase transition.
- **Pedestrian requests:**
  - `ped_req[d]` sets latch[d].
  - On entry to GO(d): if latch[d]=1, load GO_TICKS+PED_EXTRA-1 and assert `ped_walk[d]` for the whole GO phase. Clear latch[d] on entry to SLOW(d).
  - A request for d arriving during GO(d) stays latched and is serviced on the next GO(d). It does not extend the current green.
- **Pause:**
  - A rising edge of `pause` (registered edge detect) toggles `paused`.
  - While paused: prescaler, countdown, phase and direction freeze and outputs hold. Pedestrian latches still capture.
- **Reset:**
  - Phase = `start_sel`, `active_dir`=0, `remaining`=duration(start phase)-1.
  - Prescaler, `paused`, edge-detect register and pedestrian latches all clear, so `ped_walk`=0.
  - GO start via `start_sel` does not check latches.
  - Reset mid-phase or while paused returns to these values in the same cycle.

## Timing
- All outputs are decoded from registered state. They change in the cycle after the causing edge/tick, with no further latency.
- A phase of duration D lasts exactly D*TICK_DIV cycles when unpaused.
- The pause toggle takes effect in the cycle after the rising edge is seen. Holding `pause` high for several cycles toggles once.
- **Priority when a pause rising edge coincides with a final tick:** pause wins. The transition does not happen and the prescaler holds its value. On resume, the pending tick completes on the next prescaler wrap.
- **Priority between `ped_req[d]` and the latch clear** (same cycle as SLOW(d) entry): the set wins, so the request persists for the next GO(d).
- `active_dir` wraps from N_DIR-1 to 0.

## Structure
- Package `traffic_pkg`: phase enum (STOP/HOLD/GO/SLOW = 0..3) and light codes (RED/YELLOW/GREEN).
- Sub-module `tick_prescaler` (param `TICK_DIV`, input `enable`, output `tick`). It is reusable by the HEX blink logic.
- The top-level FSM, counter and pedestrian latches live in `traffic_phase_ctrl`.

## Test plan
All scenarios use N_DIR=2, TICK_DIV=2, STOP=3, GO=4, SLOW=2, HOLD=1, PED_EXTRA=2.
1. **Reset to STOP:** reset with `start_sel`=00, then run. All red for 6 cycles, then GO(0) for 8 cycles, SLOW(0) 4, HOLD 2, GO(1) 8, with `remaining` counting 3,2,1,0 in GO.
2. **Start-phase selection:**
   - `start_sel`=01 gives HOLD for 2 cycles, then GO(1).
   - 10 gives GO(0) with `remaining`=3.
   - 11 gives SLOW(0) with `light`[1:0]=01.
3. **Pause:** hold `pause` high for 2 cycles mid-GO(0) with `remaining`=2. Expect `paused`=1 and all outputs frozen for 40 cycles. A second pulse resumes, and the phase completes in the remaining cycles.
4. **Pedestrian request:** pulse `ped_req[1]` during GO(0). Expect GO(1) `remaining` to start at 5 and `ped_walk`=10 for 12 cycles. The latch clears at SLOW(1), and the next GO(1) lasts 8 cycles.
5. **Coincident events:**
   - Pause edge on the final tick of SLOW(0): the phase stays SLOW after pause.
   - `ped_req[0]` on the SLOW(0) entry cycle: the next GO(0) is extended.
6. **Reset mid-operation:** reset while paused in GO(1) with `start_sel`=10. Next cycle: `paused`=0, GO(0), `remaining`=3, `ped_walk`=0.
